mem_bus_if: RTL and testbench

- Byte-wide memory interface between the multicycle control unit/datapath and a slow external memory that uses a req/ack handshake.
- Converts single-state memread/memwrite strobes into bus transactions.
- Asserts stall to freeze the control FSM and datapath registers until the transaction completes.
- Holds the 32-bit instruction register assembled byte-by-byte under irwrite, and supplies op/funct back to the controller.

---
 rtl/mem_bus_if_if.sv | 34 +++
 rtl/mem_bus_if.sv | 159 +++++++++++++++
 tb/tb_mem_bus_if.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_if_if.sv
// Byte-wide req/ack memory bus bundle between the core-side adapter and slow external memory.
// Latency: none (wires only).
// Backpressure: master holds m_req and its qualifiers until the slave pulses m_ack.
interface mem_bus_if_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  m_req;
    logic                  m_we;
    logic [ADDR_WIDTH-1:0] m_adr;
    logic [WIDTH-1:0]      m_wdata;
    logic [WIDTH-1:0]      m_rdata;
    logic                  m_ack;

    // Core-side adapter drives the request.
    modport master (
        output m_req,
        output m_we,
        output m_adr,
        output m_wdata,
        input  m_rdata,
        input  m_ack
    );

    // Memory side answers with data and a one-cycle ack.
    modport slave (
        input  m_req,
        input  m_we,
        input  m_adr,
        input  m_wdata,
        output m_rdata,
        output m_ack
    );
endinterface

// File: rtl/mem_bus_if.sv
// Turns single-state memread/memwrite strobes into req/ack bus transactions and holds the instruction register.
// Latency: 1 IDLE stall cycle + N BUSY cycles (through ack), then one DONE cycle with stall low.
// Backpressure: stall freezes the controller/datapath until the bus acks; optional BUS_TIMEOUT_EN aborts a hung access.
module mem_bus_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [WIDTH-1:0]      writedata,
    input  logic [3:0]            irwrite,
    output logic                  stall,
    output logic [WIDTH-1:0]      readdata,
    output logic [31:0]           instr,
    output logic [5:0]            op,
    output logic [5:0]            funct,
    output logic                  err,
    mem_bus_if_if.master          bus
);

    // TIMEOUT must fit the 8-bit BUSY counter and be non-zero.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_bus_if: TIMEOUT out of range 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_nxt;
    logic                  req_any;
    logic                  ack_hit;
    logic                  timeout_hit;
    logic                  m_req_c;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic [3:0]            mask_q;

    assign req_any = memread | memwrite;
    assign ack_hit = (state_q == BUSY) && bus.m_ack;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    logic [7:0] tcnt_q;
    logic       err_q;

    // The count that would be reached this cycle decides the abort; a same-cycle ack still wins.
    assign timeout_hit = (state_q == BUSY) && !bus.m_ack && ((tcnt_q + 8'd1) == TO_LIMIT);
    assign err         = err_q;

    // BUSY cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && req_any)
                tcnt_q <= 8'd0;
            else if (state_q == BUSY && !bus.m_ack)
                tcnt_q <= tcnt_q + 8'd1;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_nxt;
    end

    // Next state plus stall/request decode; DONE is a single stall-free cycle.
    always_comb begin
        state_nxt = state_q;
        stall     = 1'b0;
        m_req_c   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = req_any;
                if (req_any)
                    state_nxt = BUSY;
            end
            BUSY: begin
                stall   = 1'b1;
                m_req_c = 1'b1;
                if (ack_hit || timeout_hit)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch in IDLE, data capture on ack (reads only), all-ones fill on timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
            mask_q   <= 4'd0;
            readdata <= '0;
            instr    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        adr_q   <= adr;
                        wdata_q <= writedata;
                        we_q    <= memwrite;
                        mask_q  <= memwrite ? 4'd0 : irwrite;
                    end
                end
                BUSY: begin
                    if (ack_hit) begin
                        if (!we_q) begin
                            readdata <= bus.m_rdata;
                            for (int k = 0; k < 4; k++) begin
                                if (mask_q[k])
                                    instr[8*k +: 8] <= bus.m_rdata[7:0];
                            end
                        end
                    end else if (timeout_hit) begin
                        if (!we_q)
                            readdata <= '1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.m_req   = m_req_c;
    assign bus.m_we    = we_q;
    assign bus.m_adr   = adr_q;
    assign bus.m_wdata = wdata_q;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if with a scoreboard of expected bus/readdata/instr per access.
// Latency: checks stall-cycle counts against 1 + ack position.
// Backpressure: bench acts as the slow memory, acking after a programmable number of BUSY cycles.
module tb_mem_bus_if;

`ifdef BUS_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 15;
`endif

    logic        clk;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [7:0]  adr;
    logic [7:0]  writedata;
    logic [3:0]  irwrite;
    logic        stall;
    logic [7:0]  readdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        err;

    int tests  = 0;
    int failed = 0;

    mem_bus_if_if #(.WIDTH(8), .ADDR_WIDTH(8)) bus ();

    mem_bus_if #(.WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .memread   (memread),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata),
        .irwrite   (irwrite),
        .stall     (stall),
        .readdata  (readdata),
        .instr     (instr),
        .op        (op),
        .funct     (funct),
        .err       (err),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [7:0]  wdata;
        logic [7:0]  rd;
        logic [31:0] instr;
        int          stalls;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  m_rd   = 8'h00;
    logic [31:0] m_inst = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access as seen by the controller; ack_at = BUSY cycle carrying the ack, 0 = never ack.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                          input logic [3:0] irw, input logic [7:0] rdat, input int ack_at, input string tag);
        exp_t e;
        exp_t got;
        int   stall_cnt;
        int   busy;
        bit   done;
        e.we    = wr;
        e.adr   = a;
        e.wdata = wd;
        if (!wr) begin
            if (ack_at != 0) begin
                m_rd = rdat;
                for (int k = 0; k < 4; k++)
                    if (irw[k]) m_inst[8*k +: 8] = rdat;
            end else begin
                m_rd = 8'hFF;
            end
        end
        e.rd     = m_rd;
        e.instr  = m_inst;
        e.stalls = 1 + ((ack_at != 0) ? ack_at : TB_TIMEOUT);
        sb.push_back(e);

        stall_cnt = 0;
        busy      = 0;
        done      = 0;
        @(negedge clk);
        memread   = rd;
        memwrite  = wr;
        adr       = a;
        writedata = wd;
        irwrite   = irw;
        for (int cyc = 0; cyc < 64; cyc++) begin
            #1;
            if (stall) begin
                stall_cnt++;
                if (bus.m_req) begin
                    busy++;
                    chk({tag, ".m_we"},    {31'd0, bus.m_we}, {31'd0, e.we});
                    chk({tag, ".m_adr"},   {24'd0, bus.m_adr}, {24'd0, e.adr});
                    chk({tag, ".m_wdata"}, {24'd0, bus.m_wdata}, {24'd0, e.wdata});
                end
                if (bus.m_req && busy == ack_at) begin
                    bus.m_ack   = 1'b1;
                    bus.m_rdata = rdat;
                end else begin
                    bus.m_ack   = 1'b0;
                    bus.m_rdata = 8'h00;
                end
            end else begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        bus.m_ack = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 4'd0;
        tests++;
        if (!done) begin
            failed++;
            $display("FAIL %s.done: observed no DONE within 64 cycles, required DONE", tag);
        end else begin
            tests--;
            got = sb.pop_front();
            chk({tag, ".done_req"}, {31'd0, bus.m_req}, 32'd0);
            chk({tag, ".stalls"},   stall_cnt, got.stalls);
            chk({tag, ".readdata"}, {24'd0, readdata}, {24'd0, got.rd});
            chk({tag, ".instr"},    instr, got.instr);
        end
        @(negedge clk);
        #1;
        chk({tag, ".idle_stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        memread     = 1'b0;
        memwrite    = 1'b0;
        adr         = 8'h00;
        writedata   = 8'h00;
        irwrite     = 4'd0;
        bus.m_ack   = 1'b0;
        bus.m_rdata = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state, and ack pulses in IDLE must not start or complete anything.
        #1;
        chk("rst.stall",    {31'd0, stall}, 32'd0);
        chk("rst.m_req",    {31'd0, bus.m_req}, 32'd0);
        chk("rst.m_we",     {31'd0, bus.m_we}, 32'd0);
        chk("rst.m_adr",    {24'd0, bus.m_adr}, 32'd0);
        chk("rst.m_wdata",  {24'd0, bus.m_wdata}, 32'd0);
        chk("rst.readdata", {24'd0, readdata}, 32'd0);
        chk("rst.instr",    instr, 32'd0);
        chk("rst.err",      {31'd0, err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.m_ack   = 1'b1;
            bus.m_rdata = 8'h55;
            #1;
            chk("idle_ack.m_req", {31'd0, bus.m_req}, 32'd0);
        end
        @(negedge clk);
        bus.m_ack = 1'b0;
        #1;
        chk("idle_ack.readdata", {24'd0, readdata}, 32'd0);
        chk("idle_ack.instr",    instr, 32'd0);

        // Instruction fetch, one byte lane per access, ack on 2nd BUSY cycle.
        access(1'b1, 1'b0, 8'h00, 8'h00, 4'b0001, 8'h20, 2, "fetch0");
        access(1'b1, 1'b0, 8'h01, 8'h00, 4'b0010, 8'h08, 2, "fetch1");
        access(1'b1, 1'b0, 8'h02, 8'h00, 4'b0100, 8'h00, 2, "fetch2");
        access(1'b1, 1'b0, 8'h03, 8'h00, 4'b1000, 8'h8C, 2, "fetch3");
        chk("fetch.instr", instr, 32'h8C000820);
        chk("fetch.op",    {26'd0, op}, 32'h23);
        chk("fetch.funct", {26'd0, funct}, 32'h20);

        // Store with ack in first BUSY cycle.
        access(1'b0, 1'b1, 8'h40, 8'h5A, 4'b0000, 8'hC3, 1, "write");

        // Read and write together behaves as a write; instr untouched despite full mask.
        access(1'b1, 1'b1, 8'h41, 8'h33, 4'b1111, 8'hEE, 3, "rdwr");

        // Plain data read with no instr lanes, then a multi-lane read.
        access(1'b1, 1'b0, 8'h80, 8'h00, 4'b0000, 8'h6B, 5, "dread");
        access(1'b1, 1'b0, 8'h81, 8'h00, 4'b0101, 8'hA7, 1, "dup");

`ifdef BUS_TIMEOUT_EN
        access(1'b1, 1'b0, 8'h10, 8'h00, 4'b1111, 8'h00, 0, "tmo");
        chk("tmo.err", {31'd0, err}, 32'd1);
        access(1'b1, 1'b0, 8'h11, 8'h00, 4'b0000, 8'h77, 2, "tmo_after");
        chk("tmo_after.err", {31'd0, err}, 32'd1);
        @(negedge clk);
        reset  = 1'b1;
        m_rd   = 8'h00;
        m_inst = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("tmo_rst.err", {31'd0, err}, 32'd0);
        access(1'b1, 1'b0, 8'h12, 8'h00, 4'b0001, 8'h3C, TB_TIMEOUT, "ack_at_limit");
        chk("ack_at_limit.err", {31'd0, err}, 32'd0);
`endif

        // Reset during BUSY with a simultaneous ack: abort, no capture.
        @(negedge clk);
        memread = 1'b1;
        adr     = 8'h20;
        irwrite = 4'b1111;
        @(negedge clk);
        #1;
        chk("rst_busy.m_req_before", {31'd0, bus.m_req}, 32'd1);
        bus.m_ack   = 1'b1;
        bus.m_rdata = 8'hAA;
        reset       = 1'b1;
        memread     = 1'b0;
        irwrite     = 4'd0;
        @(negedge clk);
        bus.m_ack = 1'b0;
        reset     = 1'b0;
        #1;
        chk("rst_busy.m_req",    {31'd0, bus.m_req}, 32'd0);
        chk("rst_busy.stall",    {31'd0, stall}, 32'd0);
        chk("rst_busy.readdata", {24'd0, readdata}, 32'd0);
        chk("rst_busy.instr",    instr, 32'd0);
        chk("rst_busy.m_adr",    {24'd0, bus.m_adr}, 32'd0);
        chk("rst_busy.err",      {31'd0, err}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst_busy.idle_req", {31'd0, bus.m_req}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
